// File: rtl/pipe_controller_pkg.sv
// Shared widths, defaults and fetch-state encoding for the pipe front-end controller.
package pipe_controller_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] WORD_STEP             = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_ADDRESS_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pipe_controller_issue_buffer.sv
// Single-entry issue buffer: valid/data/address, a load wins over a same-cycle consume/flush.
module pipe_issue_buffer
    import pipe_controller_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDRESS = RESET_ADDRESS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [INSTR_W-1:0] loadData,
    input  logic [ADDR_W-1:0]  loadAddress,
    input  logic               clear,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [ADDR_W-1:0]  address
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            data    <= '0;
            address <= RESET_ADDRESS;
        end else if (load) begin
            valid   <= 1'b1;
            data    <= loadData;
            address <= loadAddress;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Front-end controller feeding the first pipe stage from a one-word fetch buffer.
// Optional PIPE_CONTROLLER_COUNTERS_EN adds injected/bubble cycle counters.
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDRESS = RESET_ADDRESS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               stageBusy,
    input  logic               jumpEnable,
    input  logic [ADDR_W-1:0]  jumpAddress,
    output logic               fetchRequest,
    output logic [ADDR_W-1:0]  fetchAddress,
    input  logic               fetchAck,
    input  logic [INSTR_W-1:0] fetchData,
    output logic               stepPipe,
    output logic               pipeStall,
    output logic [INSTR_W-1:0] currentInstruction,
    output logic [ADDR_W-1:0]  programCounter,
    output logic               halted
`ifdef PIPE_CONTROLLER_COUNTERS_EN
    ,
    output logic [31:0]        injectedCount,
    output logic [31:0]        bubbleCount
`endif
);

    fetch_state_t      state, state_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] nextAddress, next_addr_n;
    logic              halted_n;
    logic              buf_load;
    logic              buf_valid;
    logic              inject;

    assign stepPipe  = rst && !stageBusy;
    assign pipeStall = !buf_valid || jumpEnable || halt;
    assign inject    = stepPipe && !pipeStall;

    pipe_issue_buffer #(
        .RESET_ADDRESS(RESET_ADDRESS)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .loadData   (fetchData),
        .loadAddress(fetchAddress),
        .clear      (jumpEnable || inject),
        .valid      (buf_valid),
        .data       (currentInstruction),
        .address    (programCounter)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fetchRequest <= 1'b0;
            fetchAddress <= RESET_ADDRESS;
            nextAddress  <= RESET_ADDRESS;
            halted       <= 1'b0;
        end else begin
            state        <= state_n;
            fetchRequest <= req_n;
            fetchAddress <= addr_n;
            nextAddress  <= next_addr_n;
            halted       <= halted_n;
        end
    end

    // A redirect during an outstanding fetch cannot abort the bus, so FLUSH drains it.
    always_comb begin
        state_n     = state;
        req_n       = fetchRequest;
        addr_n      = fetchAddress;
        next_addr_n = nextAddress;
        buf_load    = 1'b0;
        halted_n    = halt && (state == IDLE);
        case (state)
            IDLE: begin
                if (!halt && (!buf_valid || inject)) begin
                    state_n     = FETCH;
                    req_n       = 1'b1;
                    addr_n      = jumpEnable ? jumpAddress : nextAddress;
                    next_addr_n = addr_n + WORD_STEP;
                end else if (jumpEnable) begin
                    next_addr_n = jumpAddress;
                end
            end
            FETCH: begin
                if (fetchAck) begin
                    state_n  = IDLE;
                    req_n    = 1'b0;
                    buf_load = !jumpEnable;
                    if (jumpEnable) next_addr_n = jumpAddress;
                end else if (jumpEnable) begin
                    state_n     = FLUSH;
                    next_addr_n = jumpAddress;
                end
            end
            FLUSH: begin
                if (jumpEnable) next_addr_n = jumpAddress;
                if (fetchAck) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

`ifdef PIPE_CONTROLLER_COUNTERS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            injectedCount <= '0;
            bubbleCount   <= '0;
        end else if (stepPipe) begin
            if (inject) injectedCount <= injectedCount + 32'd1;
            else        bubbleCount   <= bubbleCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Front-end controller that drives the stepPipe / pipeStall / currentInstruction inputs of the core's chain of pipe stages.
- Fetches instruction words over a request/acknowledge bus and holds one word in a single-entry issue buffer.
- Injects the buffered word into the first pipe stage, or injects a bubble (pipeStall=1) when no valid word is available.
- Handles jump redirects from the execute stage and halt requests from debug.

Parameters:
RESET_ADDRESS, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted at 0)
halt  input  1  stop injecting and stop starting new fetches
stageBusy  input  1  OR of all stages' "need another cycle" flags
jumpEnable  input  1  execute-stage redirect strobe, single cycle
jumpAddress  input  32  redirect target, word aligned
fetchRequest  output  1  fetch bus request, registered
fetchAddress  output  32  fetch bus address, registered, stable while fetchRequest=1
fetchAck  input  1  fetch data valid, single cycle
fetchData  input  32  fetched word
stepPipe  output  1  advance all stages this cycle
pipeStall  output  1  inject bubble into first stage
currentInstruction  output  32  word presented to first stage
programCounter  output  32  address of currentInstruction
halted  output  1  halt honoured and no fetch outstanding

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, fetchRequest=0, fetchAddress=RESET_ADDRESS.
- Buffer invalid; currentInstruction=0; programCounter=RESET_ADDRESS; halted=0.

Combinational outputs:
- stepPipe = rst && !stageBusy.
- pipeStall = !bufferValid || jumpEnable || halt.
- Injection occurs when stepPipe && !pipeStall.

Buffer rules:
- Injection clears bufferValid at the clock edge, unless a kept fetchAck loads the buffer in the same cycle; the load wins and bufferValid stays 1.
- Once loaded, currentInstruction and programCounter hold until the next load.

State machine:
- IDLE: no fetch outstanding.
  - If !halt and (!bufferValid or injection this cycle) then next state is FETCH, with fetchRequest<=1.
  - fetchAddress <= jumpEnable ? jumpAddress : nextAddress.
  - nextAddress starts at RESET_ADDRESS and advances by 4 on each issued fetch.
- FETCH: fetchRequest=1; fetchAddress held.
  - On fetchAck: buffer <= fetchData, programCounter <= fetchAddress, fetchRequest<=0, next state IDLE.
  - If jumpEnable arrives without ack, the bus cannot be aborted: go to FLUSH and record jumpAddress as nextAddress.
  - If jumpEnable arrives with ack, the acked word is discarded and the next state is IDLE.
- FLUSH: fetchRequest stays 1 until fetchAck.
  - Acked data is discarded.
  - A further jumpEnable overwrites the recorded target.
  - Then IDLE.
- Any jumpEnable in any state invalidates the buffer; the redirected word is in the buffer no earlier than 2 cycles after the jump.

Throughput:
- With ack in the cycle after the request, one instruction every 3 cycles (no prefetch beyond the single buffer).
- Latency from ack to injection is 1 cycle when stageBusy=0.

Halt:
- No new fetch starts while halt=1.
- An outstanding fetch completes and fills the buffer; the buffer is held and not injected.
- halted=1 when halt=1 and state==IDLE, registered.
- Deasserting halt resumes with the buffered word.

Other rules:
- stageBusy=1 freezes injection (stepPipe=0); fetches continue as the rules above allow.
- Address arithmetic wraps modulo 2^32.
- Reset mid-fetch drops the outstanding request; the bus sees fetchRequest fall asynchronously.

Optional Feature:
PIPE_CONTROLLER_COUNTERS_EN
- Defined: adds outputs injectedCount[31:0] and bubbleCount[31:0]. Each cycle with stepPipe=1 increments exactly one of them: injectedCount on injection, bubbleCount otherwise. Both wrap and reset to 0.
- Undefined: ports and logic absent.

Decomposition:
Shared package:
- State encoding localparams IDLE / FETCH / FLUSH.
- Instruction width 32 and word step 4.
- RESET_ADDRESS default.

Sub-module: pipe_issue_buffer, holding the single-entry valid/data/address with load-over-consume priority. The FSM stays in pipe_controller.

Test Plan:
- Release reset, fetchAck one cycle after each request, data 0x00000013 for every word → fetchAddress sequence 0x0, 0x4, 0x8; injections 3 cycles apart; pipeStall=1 in between.
- stageBusy held 1 for 5 cycles with buffer valid → stepPipe=0, currentInstruction and programCounter unchanged, no new fetch issued; injection on the first cycle stageBusy=0.
- jumpEnable with jumpAddress=0x100 while FETCH is outstanding → state FLUSH, acked word discarded and never injected; next fetchAddress=0x100.
- jumpEnable on the same cycle as fetchAck and an injection → pipeStall=1, acked word discarded, next fetch at jumpAddress.
- halt=1 during an outstanding fetch → fetch completes, buffer held, halted=1 the cycle after IDLE is reached; halt=0 → buffered word injected next cycle.
- rst pulled to 0 while fetchRequest=1 → fetchRequest=0 immediately, fetchAddress=RESET_ADDRESS, and with PIPE_CONTROLLER_COUNTERS_EN both counters read 0.
